clock_freq_monitor: RTL and testbench

Checks the four divided clocks produced by the clock divider stage. It counts the rising edges on each clock over a fixed window of `clk_in` cycles and compares each count against an expected value with a tolerance. It reports the pass/fail result per channel, including a separate flag for a stuck clock. It sits directly downstream of the divider and gives the test and control logic a go/no-go view of clock generation.

---
 rtl/clk_mon_pkg.sv | 24 ++
 rtl/edge_sync_counter.sv | 41 ++++
 rtl/clock_freq_monitor.sv | 124 ++++++++++++
 tb/tb_clock_freq_monitor.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the divided-clock frequency monitor.
package clk_mon_pkg;

   localparam int CNT_W  = 8;
   localparam int NUM_CH = 4;
   localparam int WIN_W  = 12;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      COUNT,
      COMPARE
   } mon_state_t;

   // 9-bit unsigned tolerance check so that exp_val + tol never wraps for 8-bit counts.
   function automatic logic out_of_tol(input logic [CNT_W-1:0] cnt,
                                       input logic [8:0]       exp_val,
                                       input logic [8:0]       tol);
      logic [8:0] cnt9;
      cnt9 = {1'b0, cnt};
      return (cnt9 > exp_val + tol) || (cnt9 + tol < exp_val);
   endfunction

endpackage

// File: rtl/edge_sync_counter.sv
// One monitored channel: two-flop synchronizer, rising-edge detect and a saturating edge counter.
module edge_sync_counter
   import clk_mon_pkg::*;
(
   input  logic             clk_in,
   input  logic             rst,
   input  logic             mon_clk,
   input  logic             clear,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   logic sync_1;
   logic sync_2;
   logic prev;
   logic rise;

   assign rise = sync_2 & ~prev;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         prev   <= 1'b0;
      end else begin
         sync_1 <= mon_clk;
         sync_2 <= sync_1;
         prev   <= sync_2;
      end
   end

   // Holds at all-ones once saturated so a runaway clock still reads as too fast.
   always_ff @(posedge clk_in) begin
      if (rst || clear) begin
         count <= '0;
      end else if (en && rise && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/clock_freq_monitor.sv
// Counts rising edges of four divided clocks over a fixed window and flags out-of-tolerance or stuck channels.
module clock_freq_monitor
   import clk_mon_pkg::*;
#(
   parameter int WINDOW = 100,
   parameter int EXP0   = 10,
   parameter int EXP1   = 13,
   parameter int EXP2   = 16,
   parameter int EXP3   = 20,
   parameter int TOL    = 1
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic [NUM_CH-1:0] mon_clk,
   input  logic              start,
   input  logic              continuous,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [NUM_CH-1:0] fail,
   output logic [NUM_CH-1:0] stuck,
   output logic [CNT_W-1:0]  edge_cnt0,
   output logic [CNT_W-1:0]  edge_cnt1,
   output logic [CNT_W-1:0]  edge_cnt2,
   output logic [CNT_W-1:0]  edge_cnt3
);

   localparam logic [NUM_CH-1:0][8:0] EXP_V    = {9'(EXP3), 9'(EXP2), 9'(EXP1), 9'(EXP0)};
   localparam logic [8:0]             TOL_V    = 9'(TOL);
   localparam logic [WIN_W-1:0]       WIN_LOAD = WIN_W'(WINDOW - 1);

   mon_state_t                    state;
   logic [WIN_W-1:0]              win_cnt;
   logic [NUM_CH-1:0][CNT_W-1:0]  live_cnt;
   logic [NUM_CH-1:0][CNT_W-1:0]  res_cnt;
   logic [NUM_CH-1:0]             cmp_fail;
   logic [NUM_CH-1:0]             cmp_stuck;
   logic                          clear_cnt;
   logic                          count_en;

   assign clear_cnt = (state == ARM);
   assign count_en  = (state == COUNT);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      edge_sync_counter u_ch (
         .clk_in  (clk_in),
         .rst     (rst),
         .mon_clk (mon_clk[i]),
         .clear   (clear_cnt),
         .en      (count_en),
         .count   (live_cnt[i])
      );
   end

   // A stuck channel always fails, even if the tolerance band reaches down to zero.
   always_comb begin
      cmp_fail  = '0;
      cmp_stuck = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cmp_stuck[i] = (live_cnt[i] == '0);
         cmp_fail[i]  = cmp_stuck[i] | out_of_tol(live_cnt[i], EXP_V[i], TOL_V);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state   <= IDLE;
         win_cnt <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         pass    <= 1'b0;
         fail    <= '0;
         stuck   <= '0;
         res_cnt <= '0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state <= ARM;
                     busy  <= 1'b1;
                  end
               end
               ARM: begin
                  win_cnt <= WIN_LOAD;
                  state   <= COUNT;
               end
               COUNT: begin
                  if (win_cnt == '0) begin
                     state <= COMPARE;
                  end else begin
                     win_cnt <= win_cnt - 1'b1;
                  end
               end
               COMPARE: begin
                  res_cnt <= live_cnt;
                  fail    <= cmp_fail;
                  stuck   <= cmp_stuck;
                  pass    <= ~|cmp_fail;
                  done    <= 1'b1;
                  if (continuous) begin
                     state <= ARM;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign edge_cnt0 = res_cnt[0];
   assign edge_cnt1 = res_cnt[1];
   assign edge_cnt2 = res_cnt[2];
   assign edge_cnt3 = res_cnt[3];

endmodule

// File: tb/tb_clock_freq_monitor.sv
// Scoreboard bench for clock_freq_monitor: predicted results are queued at start, a monitor checks each done pulse.
module tb_clock_freq_monitor;

   localparam int W_MAIN = 100;
   localparam int W_SAT  = 600;
   localparam int TOL_N  = 1;
   localparam int EXP_N [4] = '{10, 13, 16, 20};

   typedef struct packed {
      logic [31:0]     done_cyc;
      logic [3:0][7:0] cnt;
      logic [3:0]      fail;
      logic [3:0]      stuck;
      logic            pass;
      logic            busy;
   } exp_t;

   logic       clk_in = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       start_sat = 1'b0;
   logic       continuous = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] mon_clk = 4'b0;

   logic       busy, done, pass;
   logic [3:0] fail, stuck;
   logic [7:0] edge_cnt0, edge_cnt1, edge_cnt2, edge_cnt3;
   logic       s_busy, s_done, s_pass;
   logic [3:0] s_fail, s_stuck;
   logic [7:0] s_cnt0, s_cnt1, s_cnt2, s_cnt3;

   int   cyc = 0;
   int   period [4];
   int   phase [4];
   logic [3:0] dead = 4'b0;

   exp_t q_main [$];
   exp_t q_sat [$];
   exp_t last_main = '0;
   exp_t em, es;
   int   checks = 0;
   int   passes = 0;

   clock_freq_monitor dut (
      .clk_in(clk_in), .rst(rst), .mon_clk(mon_clk), .start(start),
      .continuous(continuous), .abort(abort), .busy(busy), .done(done),
      .pass(pass), .fail(fail), .stuck(stuck), .edge_cnt0(edge_cnt0),
      .edge_cnt1(edge_cnt1), .edge_cnt2(edge_cnt2), .edge_cnt3(edge_cnt3)
   );

   clock_freq_monitor #(.WINDOW(W_SAT)) dut_sat (
      .clk_in(clk_in), .rst(rst), .mon_clk(mon_clk), .start(start_sat),
      .continuous(continuous), .abort(abort), .busy(s_busy), .done(s_done),
      .pass(s_pass), .fail(s_fail), .stuck(s_stuck), .edge_cnt0(s_cnt0),
      .edge_cnt1(s_cnt1), .edge_cnt2(s_cnt2), .edge_cnt3(s_cnt3)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc++;

   // Level of channel ch as sampled by the DUT at posedge number k.
   function automatic logic wave(int ch, int k);
      if (dead[ch]) return 1'b0;
      return ((k + phase[ch]) % period[ch]) < (period[ch] / 2);
   endfunction

   always @(negedge clk_in) begin
      for (int ch = 0; ch < 4; ch++) mon_clk[ch] = wave(ch, cyc + 1);
   end

   // A rising input transition counts if first sampled within w samples from the start-accept edge s.
   function automatic exp_t predict(int s, int w, logic busy_after);
      exp_t e;
      int   n;
      int   diff;
      e = '0;
      for (int ch = 0; ch < 4; ch++) begin
         n = 0;
         for (int k = s; k < s + w; k++) begin
            if (wave(ch, k) && !wave(ch, k - 1)) n++;
         end
         if (n > 255) n = 255;
         diff = n - EXP_N[ch];
         if (diff < 0) diff = -diff;
         e.cnt[ch]   = 8'(n);
         e.stuck[ch] = (n == 0);
         e.fail[ch]  = (n == 0) || (diff > TOL_N);
      end
      e.pass     = (e.fail == 4'b0);
      e.done_cyc = 32'(s + w + 2);
      e.busy     = busy_after;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic compareResult(input string tag, input exp_t e, input logic b, input logic p,
                                input logic [3:0] f, input logic [3:0] st, input logic [7:0] c0,
                                input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3);
      checkOutput({tag, "_done_cycle"}, 32'(cyc), e.done_cyc);
      checkOutput({tag, "_busy"}, 32'(b), 32'(e.busy));
      checkOutput({tag, "_pass"}, 32'(p), 32'(e.pass));
      checkOutput({tag, "_fail"}, 32'(f), 32'(e.fail));
      checkOutput({tag, "_stuck"}, 32'(st), 32'(e.stuck));
      checkOutput({tag, "_cnt0"}, 32'(c0), 32'(e.cnt[0]));
      checkOutput({tag, "_cnt1"}, 32'(c1), 32'(e.cnt[1]));
      checkOutput({tag, "_cnt2"}, 32'(c2), 32'(e.cnt[2]));
      checkOutput({tag, "_cnt3"}, 32'(c3), 32'(e.cnt[3]));
   endtask

   always @(negedge clk_in) begin
      if (done) begin
         if (q_main.size() == 0) begin
            checkOutput("main_unexpected_done", 32'(done), 32'd0);
         end else begin
            em = q_main.pop_front();
            compareResult("main", em, busy, pass, fail, stuck, edge_cnt0, edge_cnt1, edge_cnt2, edge_cnt3);
            last_main = em;
         end
      end
   end

   always @(negedge clk_in) begin
      if (s_done) begin
         if (q_sat.size() == 0) begin
            checkOutput("sat_unexpected_done", 32'(s_done), 32'd0);
         end else begin
            es = q_sat.pop_front();
            compareResult("sat", es, s_busy, s_pass, s_fail, s_stuck, s_cnt0, s_cnt1, s_cnt2, s_cnt3);
         end
      end
   end

   task automatic applyStimulus(input bit sat, input logic busy_after, output int s);
      @(negedge clk_in);
      s = cyc + 1;
      if (sat) begin
         start_sat = 1'b1;
         q_sat.push_back(predict(s, W_SAT, busy_after));
      end else begin
         start = 1'b1;
         q_main.push_back(predict(s, W_MAIN, busy_after));
      end
      @(negedge clk_in);
      start     = 1'b0;
      start_sat = 1'b0;
   endtask

   task automatic setConfig(input int p0, input int p1, input int p2, input int p3, input logic [3:0] dm);
      @(negedge clk_in);
      period[0] = p0; period[1] = p1; period[2] = p2; period[3] = p3;
      for (int ch = 0; ch < 4; ch++) phase[ch] = 0;
      dead = dm;
      repeat (6) @(negedge clk_in);
   endtask

   task automatic waitDrain(input int max_cycles);
      int n = 0;
      while ((q_main.size() != 0 || q_sat.size() != 0) && n < max_cycles) begin
         @(negedge clk_in);
         n++;
      end
      checkOutput("pending_results", 32'(q_main.size() + q_sat.size()), 32'd0);
      q_main.delete();
      q_sat.delete();
      @(negedge clk_in);
   endtask

   task automatic checkZero(input string tag);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_pass"}, 32'(pass), 32'd0);
      checkOutput({tag, "_fail"}, 32'(fail), 32'd0);
      checkOutput({tag, "_stuck"}, 32'(stuck), 32'd0);
      checkOutput({tag, "_cnts"}, {edge_cnt3, edge_cnt2, edge_cnt1, edge_cnt0}, 32'd0);
   endtask

   task automatic checkHeld(input string tag);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_pass"}, 32'(pass), 32'(last_main.pass));
      checkOutput({tag, "_fail"}, 32'(fail), 32'(last_main.fail));
      checkOutput({tag, "_stuck"}, 32'(stuck), 32'(last_main.stuck));
      checkOutput({tag, "_cnts"}, {edge_cnt3, edge_cnt2, edge_cnt1, edge_cnt0}, 32'(last_main.cnt));
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout at cycle %0d", cyc);
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      int s;
      for (int ch = 0; ch < 4; ch++) begin
         period[ch] = 10;
         phase[ch]  = 0;
      end
      repeat (4) @(negedge clk_in);
      checkZero("reset");
      checkOutput("reset_sat_done", 32'(s_done), 32'd0);
      rst = 1'b0;

      $display("[TB] nominal clocks");
      setConfig(10, 8, 6, 5, 4'b0000);
      applyStimulus(0, 1'b0, s);
      waitDrain(200);

      $display("[TB] channel 2 stuck low");
      setConfig(10, 8, 6, 5, 4'b0100);
      applyStimulus(0, 1'b0, s);
      waitDrain(200);

      $display("[TB] channel 3 at half clk_in rate, long window");
      setConfig(10, 8, 6, 2, 4'b0000);
      applyStimulus(1, 1'b0, s);
      waitDrain(700);

      $display("[TB] continuous mode");
      setConfig(10, 8, 6, 5, 4'b0000);
      continuous = 1'b1;
      applyStimulus(0, 1'b1, s);
      q_main.push_back(predict(s + 102, W_MAIN, 1'b1));
      q_main.push_back(predict(s + 204, W_MAIN, 1'b1));
      q_main.push_back(predict(s + 306, W_MAIN, 1'b0));
      while (cyc < s + 356) @(negedge clk_in);
      continuous = 1'b0;
      waitDrain(300);
      repeat (120) @(negedge clk_in);
      checkOutput("continuous_end_busy", 32'(busy), 32'd0);

      $display("[TB] abort mid-window");
      setConfig(10, 8, 6, 5, 4'b0001);
      applyStimulus(0, 1'b0, s);
      waitDrain(200);
      @(negedge clk_in);
      s = cyc + 1;
      start = 1'b1;
      @(negedge clk_in);
      start = 1'b0;
      while (cyc < s + 50) @(negedge clk_in);
      abort = 1'b1;
      @(negedge clk_in);
      abort = 1'b0;
      checkOutput("abort_done", 32'(done), 32'd0);
      checkHeld("abort_next");
      repeat (W_MAIN + 20) @(negedge clk_in);
      checkHeld("abort_later");

      $display("[TB] reset mid-window");
      @(negedge clk_in);
      s = cyc + 1;
      start = 1'b1;
      @(negedge clk_in);
      start = 1'b0;
      while (cyc < s + 50) @(negedge clk_in);
      rst = 1'b1;
      @(negedge clk_in);
      rst = 1'b0;
      checkZero("midreset");
      repeat (W_MAIN + 20) @(negedge clk_in);
      checkZero("midreset_later");

      $display("[TB] start while busy");
      setConfig(10, 8, 6, 5, 4'b0000);
      applyStimulus(0, 1'b0, s);
      repeat (30) @(negedge clk_in);
      start = 1'b1;
      @(negedge clk_in);
      start = 1'b0;
      waitDrain(200);
      repeat (120) @(negedge clk_in);
      checkOutput("start_busy_idle", 32'(busy), 32'd0);

      $display("[TB] randomized clock configurations");
      for (int t = 0; t < 6; t++) begin
         @(negedge clk_in);
         for (int ch = 0; ch < 4; ch++) begin
            period[ch] = int'($urandom_range(14, 2));
            phase[ch]  = int'($urandom_range(period[ch] - 1, 0));
            dead[ch]   = ($urandom_range(7, 0) == 0);
         end
         repeat (6) @(negedge clk_in);
         applyStimulus(0, 1'b0, s);
         waitDrain(200);
      end

      repeat (10) @(negedge clk_in);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
